// File: rtl/memory_stage.sv
// Memory-access pipeline stage: registers execute results, runs a single-outstanding
// load/store on the data-memory port and drives the M/W forwarding buses.
module memory_stage #(
  parameter int CORE         = 0,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    valid_x,
  input  logic [DATA_WIDTH-1:0]   ALU_result,
  input  logic [DATA_WIDTH-1:0]   store_data,
  input  logic [2:0]              funct3,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [4:0]              regDest_x,
  input  logic                    regEn_x,
  output logic                    stall,
  output logic                    d_req,
  output logic                    d_we,
  output logic [ADDRESS_BITS-1:0] d_addr,
  output logic [DATA_WIDTH-1:0]   d_wdata,
  output logic [3:0]              d_byteen,
  input  logic                    d_ready,
  input  logic                    d_rvalid,
  input  logic [DATA_WIDTH-1:0]   d_rdata,
  output logic [DATA_WIDTH-1:0]   regRead_m,
  output logic [4:0]              regDest_m,
  output logic                    regEn_m,
  output logic [DATA_WIDTH-1:0]   regRead_w,
  output logic [4:0]              regDest_w,
  output logic                    regEn_w,
  output logic                    misaligned,
  input  logic                    report
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t                  state_reg;
  logic                    m_valid_reg;
  logic [DATA_WIDTH-1:0]   m_result_reg;
  logic [DATA_WIDTH-1:0]   m_store_reg;
  logic [2:0]              m_funct3_reg;
  logic                    m_read_reg;
  logic                    m_write_reg;
  logic [4:0]              m_dest_reg;
  logic                    m_en_reg;
  logic                    w_en_reg;
  logic [DATA_WIDTH-1:0]   w_data_reg;
  logic [4:0]              w_dest_reg;

  logic                    x_memop, x_misaligned;
  logic                    m_memop, m_misaligned, m_access;
  logic                    done;
  logic [DATA_WIDTH-1:0]   shifted_rdata;
  logic [DATA_WIDTH-1:0]   load_data;
  logic                    w_en_next;
  logic [DATA_WIDTH-1:0]   w_data_next;
  logic                    unused_ok;

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b01:   return a[0];
      2'b10:   return a != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  assign x_memop      = valid_x & (mem_read | mem_write);
  assign x_misaligned = x_memop & is_misaligned(funct3, ALU_result[1:0]);
  assign m_memop      = m_valid_reg & (m_read_reg | m_write_reg);
  assign m_misaligned = m_memop & is_misaligned(m_funct3_reg, m_result_reg[1:0]);
  assign m_access     = m_memop & ~m_misaligned;

  assign done  = ((state_reg == REQ) & d_ready & m_write_reg) |
                 ((state_reg == RESP) & d_rvalid);
  assign stall = m_access & ~done;

  // Request fields come straight from M, which is frozen while stalled, so they stay stable.
  assign d_req  = (state_reg == REQ);
  assign d_we   = d_req & m_write_reg;
  assign d_addr = d_req ? m_result_reg[ADDRESS_BITS-1:0] : '0;

  always_comb begin
    d_wdata  = '0;
    d_byteen = 4'b0000;
    if (d_we) begin
      case (m_funct3_reg[1:0])
        2'b00: begin
          d_wdata  = {(DATA_WIDTH/8){m_store_reg[7:0]}};
          d_byteen = 4'b0001 << m_result_reg[1:0];
        end
        2'b01: begin
          d_wdata  = {(DATA_WIDTH/16){m_store_reg[15:0]}};
          d_byteen = m_result_reg[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          d_wdata  = m_store_reg;
          d_byteen = 4'b1111;
        end
      endcase
    end
  end

  assign shifted_rdata = d_rdata >> {m_result_reg[1:0], 3'b000};

  always_comb begin
    case (m_funct3_reg)
      3'b000:  load_data = {{(DATA_WIDTH-8){shifted_rdata[7]}}, shifted_rdata[7:0]};
      3'b001:  load_data = {{(DATA_WIDTH-16){shifted_rdata[15]}}, shifted_rdata[15:0]};
      3'b100:  load_data = {{(DATA_WIDTH-8){1'b0}}, shifted_rdata[7:0]};
      3'b101:  load_data = {{(DATA_WIDTH-16){1'b0}}, shifted_rdata[15:0]};
      default: load_data = shifted_rdata;
    endcase
  end

  // Only a completed load or a non-memory op writes back; x0 never does.
  always_comb begin
    w_en_next   = 1'b0;
    w_data_next = m_result_reg;
    if (m_valid_reg && m_en_reg && (m_dest_reg != 5'd0)) begin
      if (!m_memop) begin
        w_en_next = 1'b1;
      end else if (m_access && m_read_reg && (state_reg == RESP) && d_rvalid) begin
        w_en_next   = 1'b1;
        w_data_next = load_data;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      m_valid_reg  <= 1'b0;
      m_result_reg <= '0;
      m_store_reg  <= '0;
      m_funct3_reg <= 3'b000;
      m_read_reg   <= 1'b0;
      m_write_reg  <= 1'b0;
      m_dest_reg   <= 5'd0;
      m_en_reg     <= 1'b0;
      w_en_reg     <= 1'b0;
      w_data_reg   <= '0;
      w_dest_reg   <= 5'd0;
    end else begin
      if (!stall) begin
        state_reg    <= (x_memop && !x_misaligned) ? REQ : IDLE;
        m_valid_reg  <= valid_x;
        m_result_reg <= ALU_result;
        m_store_reg  <= store_data;
        m_funct3_reg <= funct3;
        m_read_reg   <= mem_read;
        m_write_reg  <= mem_write;
        m_dest_reg   <= regDest_x;
        m_en_reg     <= regEn_x;
      end else if ((state_reg == REQ) && d_ready && m_read_reg) begin
        state_reg <= RESP;
      end
      w_en_reg   <= w_en_next;
      w_data_reg <= w_data_next;
      w_dest_reg <= m_dest_reg;
    end
  end

  assign regRead_m  = m_result_reg;
  assign regDest_m  = m_dest_reg;
  assign regEn_m    = m_valid_reg & m_en_reg & ~m_read_reg;
  assign regRead_w  = w_data_reg;
  assign regDest_w  = w_dest_reg;
  assign regEn_w    = w_en_reg;
  assign misaligned = m_misaligned;

  // The debug dump hook and core index have no hardware function.
  assign unused_ok = report ^ CORE[0];

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage: ALU forward, stores, loads,
// misalignment, back-to-back accesses and reset during an outstanding load.
module tb_memory_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        valid_x;
  logic [31:0] ALU_result, store_data;
  logic [2:0]  funct3;
  logic        mem_read, mem_write;
  logic [4:0]  regDest_x;
  logic        regEn_x;
  logic        stall, d_req, d_we;
  logic [19:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_byteen;
  logic        d_ready, d_rvalid;
  logic [31:0] d_rdata;
  logic [31:0] regRead_m, regRead_w;
  logic [4:0]  regDest_m, regDest_w;
  logic        regEn_m, regEn_w, misaligned;
  logic        report;

  int checks = 0;
  int errors = 0;

  memory_stage #(.CORE(0), .DATA_WIDTH(32), .ADDRESS_BITS(20)) dut (
    .clock(clock), .reset(reset), .valid_x(valid_x), .ALU_result(ALU_result),
    .store_data(store_data), .funct3(funct3), .mem_read(mem_read), .mem_write(mem_write),
    .regDest_x(regDest_x), .regEn_x(regEn_x), .stall(stall), .d_req(d_req), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_byteen(d_byteen), .d_ready(d_ready),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .regRead_m(regRead_m), .regDest_m(regDest_m),
    .regEn_m(regEn_m), .regRead_w(regRead_w), .regDest_w(regDest_w), .regEn_w(regEn_w),
    .misaligned(misaligned), .report(report)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] sd,
                       input logic [2:0] f3, input logic rd, input logic wr,
                       input logic [4:0] dest, input logic en);
    valid_x = v; ALU_result = alu; store_data = sd; funct3 = f3;
    mem_read = rd; mem_write = wr; regDest_x = dest; regEn_x = en;
  endtask

  task automatic bubble();
    drive(1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  // Load accepted immediately, response `wait_cycles` RESP cycles after acceptance.
  task automatic do_load(input string name, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] rdata, input int wait_cycles,
                         input logic [31:0] exp);
    drive(1'b1, addr, 32'h0, f3, 1'b1, 1'b0, 5'd7, 1'b1);
    d_ready = 1'b1;
    step();
    check({name, "_req"}, {31'b0, d_req}, 32'd1);
    check({name, "_addr"}, {12'b0, d_addr}, addr & 32'hFFFFF);
    check({name, "_en_m"}, {31'b0, regEn_m}, 32'd0);
    step();
    d_ready = 1'b0;
    for (int i = 1; i < wait_cycles; i++) begin
      check({name, "_resp_stall"}, {31'b0, stall}, 32'd1);
      step();
    end
    d_rvalid = 1'b1; d_rdata = rdata; bubble();
    #1;
    check({name, "_done_stall"}, {31'b0, stall}, 32'd0);
    step();
    d_rvalid = 1'b0;
    check({name, "_en_w"}, {31'b0, regEn_w}, 32'd1);
    check({name, "_data_w"}, regRead_w, exp);
    check({name, "_dest_w"}, {27'b0, regDest_w}, 32'd7);
  endtask

  initial begin
    reset = 1'b1; report = 1'b0; d_ready = 1'b0; d_rvalid = 1'b0; d_rdata = 32'h0;
    bubble();
    step(); step();
    check("rst_req", {31'b0, d_req}, 32'd0);
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_en_m", {31'b0, regEn_m}, 32'd0);
    check("rst_en_w", {31'b0, regEn_w}, 32'd0);
    check("rst_byteen", {28'b0, d_byteen}, 32'd0);
    check("rst_mis", {31'b0, misaligned}, 32'd0);
    reset = 1'b0;
    step();

    // ALU op to x5
    drive(1'b1, 32'h0000_1234, 32'h0, 3'b000, 1'b0, 1'b0, 5'd5, 1'b1);
    step(); bubble();
    check("alu_en_m", {31'b0, regEn_m}, 32'd1);
    check("alu_dest_m", {27'b0, regDest_m}, 32'd5);
    check("alu_read_m", regRead_m, 32'h1234);
    check("alu_stall", {31'b0, stall}, 32'd0);
    step();
    check("alu_en_w", {31'b0, regEn_w}, 32'd1);
    check("alu_read_w", regRead_w, 32'h1234);
    check("alu_dest_w", {27'b0, regDest_w}, 32'd5);

    // ALU op to x0 never writes back
    drive(1'b1, 32'h55, 32'h0, 3'b000, 1'b0, 1'b0, 5'd0, 1'b1);
    step(); bubble(); step();
    check("x0_en_w", {31'b0, regEn_w}, 32'd0);

    // SB at 0x103, ready low for 2 cycles
    drive(1'b1, 32'h103, 32'hAB, 3'b000, 1'b0, 1'b1, 5'd0, 1'b0);
    d_ready = 1'b0;
    step(); bubble();
    check("sb_req1", {31'b0, d_req}, 32'd1);
    check("sb_we", {31'b0, d_we}, 32'd1);
    check("sb_byteen", {28'b0, d_byteen}, 32'b1000);
    check("sb_wdata", d_wdata, 32'hABABABAB);
    check("sb_addr", {12'b0, d_addr}, 32'h103);
    check("sb_stall1", {31'b0, stall}, 32'd1);
    step();
    check("sb_req2", {31'b0, d_req}, 32'd1);
    check("sb_stall2", {31'b0, stall}, 32'd1);
    step();
    d_ready = 1'b1; #1;
    check("sb_req3", {31'b0, d_req}, 32'd1);
    check("sb_stall3", {31'b0, stall}, 32'd0);
    step();
    check("sb_req_after", {31'b0, d_req}, 32'd0);
    check("sb_en_w", {31'b0, regEn_w}, 32'd0);

    // SH at 0x102, accepted immediately
    drive(1'b1, 32'h102, 32'h0000_5678, 3'b001, 1'b0, 1'b1, 5'd0, 1'b0);
    step(); bubble();
    check("sh_byteen", {28'b0, d_byteen}, 32'b1100);
    check("sh_wdata", d_wdata, 32'h56785678);
    check("sh_stall", {31'b0, stall}, 32'd0);
    step();
    check("sh_req_after", {31'b0, d_req}, 32'd0);

    do_load("lb",  32'h102, 3'b000, 32'h0080_0000, 2, 32'hFFFF_FF80);
    do_load("lbu", 32'h102, 3'b100, 32'h0080_0000, 2, 32'h0000_0080);
    do_load("lh",  32'h102, 3'b001, 32'h8000_0000, 1, 32'hFFFF_8000);
    do_load("lhu", 32'h102, 3'b101, 32'h8000_0000, 1, 32'h0000_8000);
    do_load("lw",  32'h100, 3'b010, 32'h1234_5678, 3, 32'h1234_5678);

    // Misaligned LW at 0x102
    drive(1'b1, 32'h102, 32'h0, 3'b010, 1'b1, 1'b0, 5'd9, 1'b1);
    step(); bubble();
    check("mis_pulse", {31'b0, misaligned}, 32'd1);
    check("mis_req", {31'b0, d_req}, 32'd0);
    check("mis_stall", {31'b0, stall}, 32'd0);
    step();
    check("mis_pulse_end", {31'b0, misaligned}, 32'd0);
    check("mis_en_w", {31'b0, regEn_w}, 32'd0);

    // Back-to-back LW then SW
    d_ready = 1'b1;
    drive(1'b1, 32'h100, 32'h0, 3'b010, 1'b1, 1'b0, 5'd3, 1'b1);
    step();
    check("b2b_lw_req", {31'b0, d_req}, 32'd1);
    step();
    d_rvalid = 1'b1; d_rdata = 32'hDEAD_BEEF;
    drive(1'b1, 32'h200, 32'h1122_3344, 3'b010, 1'b0, 1'b1, 5'd0, 1'b0);
    #1;
    check("b2b_stall", {31'b0, stall}, 32'd0);
    step();
    d_rvalid = 1'b0; bubble(); #1;
    check("b2b_sw_req", {31'b0, d_req}, 32'd1);
    check("b2b_sw_we", {31'b0, d_we}, 32'd1);
    check("b2b_sw_addr", {12'b0, d_addr}, 32'h200);
    check("b2b_sw_wdata", d_wdata, 32'h1122_3344);
    check("b2b_lw_en_w", {31'b0, regEn_w}, 32'd1);
    check("b2b_lw_data_w", regRead_w, 32'hDEAD_BEEF);
    check("b2b_lw_dest_w", {27'b0, regDest_w}, 32'd3);
    step();
    check("b2b_idle", {31'b0, d_req}, 32'd0);

    // Reset during RESP
    drive(1'b1, 32'h104, 32'h0, 3'b010, 1'b1, 1'b0, 5'd4, 1'b1);
    step(); step();
    check("rr_stall_resp", {31'b0, stall}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rr_req", {31'b0, d_req}, 32'd0);
    check("rr_stall", {31'b0, stall}, 32'd0);
    bubble();
    step();
    reset = 1'b0;
    step();
    d_rvalid = 1'b1; d_rdata = 32'hCAFE_F00D;
    step();
    d_rvalid = 1'b0;
    check("rr_en_w", {31'b0, regEn_w}, 32'd0);
    step();
    check("rr_en_w2", {31'b0, regEn_w}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/memory_stage.md
# memory_stage

Memory-access pipeline stage placed directly after `execution_unit`. It registers the execute results and performs load/store transactions on a single-outstanding data-memory request/response port, with byte/halfword alignment and sign extension. It drives the M- and W-stage forwarding buses (`regRead_m/regDest_m/regEn_m`, `regRead_w/regDest_w/regEn_w`) back into execute, and stalls upstream stages while a memory access is outstanding.

## Interface
- `CORE`, 0: core index, used only in report output.
- `DATA_WIDTH`, 32: datapath width.
- `ADDRESS_BITS`, 20: data-memory address width.

- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `valid_x` in 1: execute holds a valid instruction.
- `ALU_result` in DATA_WIDTH: effective address, or the result for non-memory ops.
- `store_data` in DATA_WIDTH: forwarded rs2 value.
- `funct3` in 3: access size and signedness.
- `mem_read`, `mem_write` in 1 each: load op / store op; never both set.
- `regDest_x` in 5, `regEn_x` in 1: destination register and write enable.
- `stall` out 1: upstream must hold; this stage accepts nothing while it is high.
- `d_req` out 1, `d_we` out 1, `d_addr` out ADDRESS_BITS, `d_wdata` out DATA_WIDTH, `d_byteen` out 4: memory request.
- `d_ready` in 1: request accepted in any cycle where `d_req` and `d_ready` are both high.
- `d_rvalid` in 1, `d_rdata` in DATA_WIDTH: load response, one per accepted load.
- `regRead_m` out DATA_WIDTH, `regDest_m` out 5, `regEn_m` out 1: M-stage forward bus.
- `regRead_w` out DATA_WIDTH, `regDest_w` out 5, `regEn_w` out 1: W-stage forward bus and register-file write port.
- `misaligned` out 1: one-cycle pulse on a misaligned access.
- `report` in 1: debug `$display` dump of the stage state.

## Operation
- M register: holds the valid bit, result, store data, funct3, read/write flags, destination and enable.
  - Loads from execute on every edge where `stall` is 0.
  - `valid_x`=0 loads a bubble (valid bit cleared).
- FSM states: IDLE, REQ, RESP.
  - IDLE→REQ: M is loaded with an aligned memory op.
  - REQ: `d_req`=1. Request fields are driven combinationally from M and held stable until accepted.
  - REQ→IDLE: store accepted (`d_ready`=1).
  - REQ→RESP: load accepted.
  - RESP→IDLE: `d_rvalid`=1.
  - Back-to-back ops: if a new memory op is loaded on the completing edge, the next state is REQ, not IDLE.
- `done` = (REQ & `d_ready` & store) | (RESP & `d_rvalid`).
- `stall` = memory op in M & ~`done`. Upstream may advance on the completing edge.
- Addressing:
  - `d_addr` = `ALU_result[ADDRESS_BITS-1:0]`; the full byte address is passed through.
  - Store lanes: SB sets `d_byteen` = 1 << addr[1:0] and replicates the byte to all lanes. SH sets `d_byteen` = 0011 or 1100 and replicates the half. SW sets 1111.
- Alignment:
  - Misaligned cases: SH/LH/LHU with addr[0]=1; SW/LW with addr[1:0]≠0.
  - A misaligned op issues no request, pulses `misaligned` for one cycle, suppresses its register write and does not stall.
- Load data: `d_rdata` is shifted right by 8·addr[1:0].
  - LB(000)/LH(001) sign-extend; LBU(100)/LHU(101) zero-extend; LW(010) passes through.
- M forward bus:
  - `regRead_m` = M result.
  - `regDest_m` = M destination.
  - `regEn_m` = M valid & `regEn_x` & ~load. A pending load never forwards from M.
- W register:
  - Captures on every edge.
  - Non-memory op leaving M: the ALU result.
  - Completing load: the formatted load data.
  - Store, misaligned op, bubble, or stalled slot: `regEn_w`=0.
  - `regDest_w` = 0 always forces `regEn_w`=0.

## Timing
- Reset, asynchronous: FSM to IDLE; M and W valid bits cleared.
  - All outputs 0: `d_req`, `d_we`, `d_byteen`, `stall`, `regEn_m`, `regEn_w`, `misaligned`, the data/address buses and the dest fields.
  - A `d_rvalid` arriving after reset, while in IDLE, is ignored.
- Non-memory op: M forward in the cycle after execute; W forward one cycle later. Zero stall.
- Store latency: 1 + (cycles `d_ready` is held low).
- Load latency:
  - `regEn_w` rises on the edge after `d_rvalid`.
  - `d_rvalid` may arrive at the earliest one cycle after acceptance.
- A request is never withdrawn or changed while `d_req`=1 & `d_ready`=0.

## Test plan
- ALU op: result 0x0000_1234 to x5 → `regEn_m`=1, `regDest_m`=5 in cycle 1; `regRead_w`=0x1234, `regEn_w`=1 in cycle 2; `stall` stays 0.
- SB: `store_data`=0xAB, addr 0x103, `d_ready` low 2 cycles → `d_byteen`=1000, `d_wdata`=0xABABABAB, `d_req` held 3 cycles, `stall` high 2 cycles.
- LB: addr 0x102, `d_rdata`=0x0080_0000, `d_rvalid` 2 cycles after acceptance → `regRead_w`=0xFFFF_FF80. LBU of the same access → 0x0000_0080. `regEn_m`=0 throughout.
- LW at 0x102 → `misaligned` pulses, `d_req` stays 0, `regEn_w`=0, no stall.
- Back-to-back LW then SW: the second request is asserted in the cycle after `d_rvalid` with no idle gap; the LW data appears on the W bus.
- Reset asserted in RESP → `d_req`/`stall` drop immediately; a later `d_rvalid` produces no `regEn_w`.
